fifo_rd_packer: RTL
===================

Name: fifo_rd_packer

Overview:
- Read-clock-domain consumer that sits directly downstream of the async FIFO.
- Pops bytes from the FIFO read port whenever data is present and packs them little-endian into BYTES_PER_WORD-wide words.
- Presents each word on a valid/ready output handshake and supports an explicit flush of a partial word.
- Maintains a running byte checksum and a word counter for the rest of the read domain to use in integrity checking.

Parameters:
DATA_SIZE, 8, width of one FIFO entry (byte lane width)
BYTES_PER_WORD, 4, lanes per output word (power of two, 2..8)
CNT_W, 16, width of word counter and checksum

Ports:
clk_rd  input  1  read-domain clock, all logic on rising edge
rst  input  1  synchronous active-high reset, sampled on rising clk_rd
fifo_dout  input  DATA_SIZE  FIFO head data, show-ahead (valid whenever fifo_empty=0)
fifo_empty  input  1  FIFO empty flag (rd_empty)
fifo_rd_en  output  1  pop strobe; head consumed on the clock edge where fifo_rd_en=1
flush  input  1  single-cycle request to emit the current partial word
word_out  output  DATA_SIZE*BYTES_PER_WORD  packed word, lane 0 = first popped byte in bits [DATA_SIZE-1:0]
word_keep  output  BYTES_PER_WORD  per-lane valid mask for word_out
word_valid  output  1  word_out/word_keep valid
word_ready  input  1  downstream accept
word_cnt  output  CNT_W  count of words accepted downstream, mod 2^CNT_W
byte_sum  output  CNT_W  sum of all popped bytes, mod 2^CNT_W

Behaviour:
- Reset (rst=1 at an edge): state=FILL, lane idx=0, packing buffer=0, word_out=0, word_keep=0, word_valid=0, word_cnt=0, byte_sum=0.
  - Reset mid-HOLD drops the pending word with no handshake.
  - Reset mid-FILL discards any partially packed bytes.
- fifo_rd_en is combinational: fifo_rd_en = (state==FILL) && !fifo_empty && !rst. It is never high in HOLD.
- FILL state:
  - On each edge with fifo_rd_en=1, write fifo_dout into lane idx of the buffer, set keep bit idx, and advance idx.
  - If the popped byte lands in lane BYTES_PER_WORD-1:
    - Go to HOLD next cycle with word_valid=1 and word_keep all ones.
    - Reset idx to 0.
  - Latency: the last byte popped at edge N gives word_valid=1 after edge N.
- Flush (sampled in FILL only):
  - If idx>0 or a pop happens in the same cycle, go to HOLD with the bytes packed so far. word_keep has ones in the filled lanes; unfilled lanes of word_out are 0.
  - Pop and flush in the same cycle: the popped byte is included first, then the word is emitted. If that pop completes the word, keep is all ones.
  - With idx=0 and no pop, flush is ignored; no empty words are ever emitted.
  - Flush asserted in HOLD is ignored and is not remembered.
- HOLD state:
  - word_valid=1; word_out and word_keep are held stable until word_ready=1.
  - On an edge with word_ready=1:
    - word_valid goes to 0.
    - Buffer and keep are cleared.
    - word_cnt increments, wrapping from 2^CNT_W-1 to 0.
    - State returns to FILL.
  - A pop may occur from the next cycle onward. Peak throughput is therefore BYTES_PER_WORD bytes per BYTES_PER_WORD+1 cycles.
- byte_sum: byte_sum <= byte_sum + zero-extended fifo_dout on every edge with fifo_rd_en=1. It is visible one cycle after the pop and wraps mod 2^CNT_W.
- word_ready while word_valid=0 has no effect.
- fifo_empty toggling mid-word only stalls packing; idx and the buffer are retained indefinitely.

Test Plan:
1. Reset, then FIFO holds 0x00,0x04,0x08,0x0C with word_ready=1 -> fifo_rd_en high 4 consecutive cycles; word_out=0x0C080400, keep=4'hF, word_valid for exactly 1 cycle; word_cnt=1, byte_sum=0x0018.
2. FIFO holds 8 bytes 0x10..0x2C (step 4), word_ready held 0 for 5 cycles after the first word -> first word 0x1C181410 held stable, fifo_rd_en=0 throughout HOLD; after ready, second word 0x2C282420, word_cnt=2.
3. Pop 0xAA,0xBB, FIFO goes empty, pulse flush -> word_out=0x0000BBAA, keep=4'b0011; then flush with idx=0 and FIFO empty -> no word_valid.
4. Pop 0x01 and assert flush in the same cycle as the 3rd byte 0x03 (after 0x01,0x02) -> word_out=0x00030201, keep=4'b0111; same test on the 4th byte -> keep=4'hF, single word.
5. Assert rst during HOLD with word 0x0C080400 pending -> next cycle word_valid=0, word_cnt=0, byte_sum=0, fifo_rd_en follows !fifo_empty immediately after reset deasserts.
6. Stream 2^CNT_W words of 0xFF bytes with CNT_W=4 -> word_cnt wraps 15->0; byte_sum equals (count*0xFF) mod 16.

Source files
------------

// File: rtl/fifo_rd_packer_if.sv
// ============================================================================
//  Module      : fifo_rd_packer_if
//  Description : Bundles the FIFO read port and the packed-word output
//                handshake of fifo_rd_packer.
//                  fifo_dout / fifo_empty / fifo_rd_en : show-ahead FIFO read
//                  flush                               : emit partial word
//                  word_out / word_keep / word_valid /
//                  word_ready                          : packed-word handshake
//                  word_cnt / byte_sum                 : integrity counters
//                master : the packer side
//                slave  : the surrounding read-domain logic
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_rd_packer_if #(
    parameter int DATA_SIZE      = 8,
    parameter int BYTES_PER_WORD = 4,
    parameter int CNT_W          = 16
);
    logic [DATA_SIZE-1:0]                fifo_dout;
    logic                                fifo_empty;
    logic                                fifo_rd_en;
    logic                                flush;
    logic [DATA_SIZE*BYTES_PER_WORD-1:0] word_out;
    logic [BYTES_PER_WORD-1:0]           word_keep;
    logic                                word_valid;
    logic                                word_ready;
    logic [CNT_W-1:0]                    word_cnt;
    logic [CNT_W-1:0]                    byte_sum;

    modport master (
        input  fifo_dout, fifo_empty, flush, word_ready,
        output fifo_rd_en, word_out, word_keep, word_valid, word_cnt, byte_sum
    );

    modport slave (
        output fifo_dout, fifo_empty, flush, word_ready,
        input  fifo_rd_en, word_out, word_keep, word_valid, word_cnt, byte_sum
    );
endinterface

`default_nettype wire

// File: rtl/fifo_rd_packer.sv
// ============================================================================
//  Module      : fifo_rd_packer
//  Description : Read-domain consumer of the async FIFO. Pops bytes whenever
//                the FIFO is non-empty, packs them little-endian into
//                BYTES_PER_WORD-lane words and offers each word on a
//                valid/ready handshake. A flush request emits a partial word.
//                Keeps a running byte checksum and an accepted-word counter.
//  Ports       : clk_rd - read-domain clock (rising edge)
//                rst    - synchronous active-high reset
//                bus    - fifo_rd_packer_if.master (FIFO read port, flush,
//                         word handshake, word_cnt, byte_sum)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_rd_packer #(
    parameter int DATA_SIZE      = 8,
    parameter int BYTES_PER_WORD = 4,
    parameter int CNT_W          = 16
) (
    input  wire logic          clk_rd,
    input  wire logic          rst,
    fifo_rd_packer_if.master   bus
);

    localparam int c_WORD_W = DATA_SIZE * BYTES_PER_WORD;
    localparam int c_IDX_W  = $clog2(BYTES_PER_WORD);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(BYTES_PER_WORD - 1);

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t                    state_q,    state_d;
    logic [c_IDX_W-1:0]        idx_q,      idx_d;
    logic [c_WORD_W-1:0]       buf_q,      buf_d;
    logic [BYTES_PER_WORD-1:0] keep_q,     keep_d;
    logic [CNT_W-1:0]          word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]          byte_sum_q, byte_sum_d;
    logic                      w_pop;

    // Pop is gated by rst so nothing is consumed from the FIFO while the
    // packer is being reset.
    assign w_pop = (state_q == ST_FILL) && !bus.fifo_empty && !rst;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        buf_d      = buf_q;
        keep_d     = keep_q;
        word_cnt_d = word_cnt_q;
        byte_sum_d = byte_sum_q;

        if (w_pop) begin
            byte_sum_d = byte_sum_q + CNT_W'(bus.fifo_dout);
        end

        case (state_q)
            ST_FILL: begin
                if (w_pop) begin
                    buf_d[idx_q*DATA_SIZE +: DATA_SIZE] = bus.fifo_dout;
                    keep_d[idx_q]                       = 1'b1;
                    if (idx_q == c_LAST_IDX || bus.flush) begin
                        // Popped byte is included before the word goes out.
                        idx_d   = '0;
                        state_d = ST_HOLD;
                    end else begin
                        idx_d = idx_q + c_IDX_W'(1);
                    end
                end else if (bus.flush && idx_q != '0) begin
                    // Flush with nothing packed is dropped: no empty words.
                    idx_d   = '0;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.word_ready) begin
                    buf_d      = '0;
                    keep_d     = '0;
                    word_cnt_d = word_cnt_q + CNT_W'(1);
                    state_d    = ST_FILL;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge clk_rd) begin
        if (rst) begin
            state_q    <= ST_FILL;
            idx_q      <= '0;
            buf_q      <= '0;
            keep_q     <= '0;
            word_cnt_q <= '0;
            byte_sum_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            buf_q      <= buf_d;
            keep_q     <= keep_d;
            word_cnt_q <= word_cnt_d;
            byte_sum_q <= byte_sum_d;
        end
    end

    assign bus.fifo_rd_en = w_pop;
    assign bus.word_out   = buf_q;
    assign bus.word_keep  = keep_q;
    assign bus.word_valid = (state_q == ST_HOLD);
    assign bus.word_cnt   = word_cnt_q;
    assign bus.byte_sum   = byte_sum_q;

endmodule

`default_nettype wire
